idwt_module: RTL and testbench

//  Inverse of the forward DWT row stage: one-level integer Haar (lifting) reconstruction of one image row.

---
 rtl/idwt_module_pkg.sv | 19 +
 rtl/idwt_module_if.sv | 16 +
 rtl/idwt_module_lift.sv | 26 ++
 rtl/idwt_module.sv | 95 +++++++++
 tb/tb_idwt_module.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/idwt_module_pkg.sv
// Package essentials: shared row length, FSM state type and the
// saturation helper used by the Haar lifting datapath.
//   LENGTH        default pixels per row
//   idwt_state_t  IDLE -> LOAD -> DONE -> EMIT
//   sat8          clamp a 10-bit signed value to the pixel range [0,255]
package essentials;

  localparam int LENGTH = 256;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, EMIT} idwt_state_t;

  // Bit 9 set means negative; otherwise bit 8 set means above 255.
  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    if (v[9])      return 8'd0;
    else if (v[8]) return 8'hFF;
    else           return v[7:0];
  endfunction

endpackage

// File: rtl/idwt_module_if.sv
// Interface idwt_if: coefficient input and pixel output handshake of the
// inverse DWT row stage.
//   en, s, d                     driven by the coefficient reader (master)
//   rdy, result, out, out_valid  driven by the reconstruction block (slave)
interface idwt_if;
  logic       en;
  logic [7:0] s;
  logic [7:0] d;
  logic       rdy;
  logic       result;
  logic [7:0] out;
  logic       out_valid;

  modport master (output en, s, d, input rdy, result, out, out_valid);
  modport slave  (input en, s, d, output rdy, result, out, out_valid);
endinterface

// File: rtl/idwt_module_lift.sv
// idwt_lift_unit: combinational integer Haar inverse lifting for one pair.
//   s  in  8  approximation coefficient, unsigned
//   d  in  8  detail coefficient, signed two's complement
//   a  out 8  even pixel, sat8(t + d)
//   b  out 8  odd pixel,  sat8(t), with t = s - floor(d/2)
module idwt_lift_unit
  import essentials::*;
(
  input  logic [7:0] s,
  input  logic [7:0] d,
  output logic [7:0] a,
  output logic [7:0] b
);

  logic signed [9:0] d_ext;
  logic signed [9:0] t;

  always_comb begin
    d_ext = {{2{d[7]}}, d};
    t     = $signed({2'b00, s}) - (d_ext >>> 1);
    b     = sat8(t);
    // a is built from the unsaturated t so the pair stays an exact inverse.
    a     = sat8(t + d_ext);
  end

endmodule

// File: rtl/idwt_module.sv
// idwt_module: one-level inverse Haar reconstruction of one image row.
// Takes LENGTH/2 (s,d) pairs, one per cycle after the start strobe,
// buffers the row, pulses result, then streams LENGTH pixels.
//   clk, reset   clock and synchronous active-high reset
//   bus (slave)  en/s/d in; rdy/result/out/out_valid out
module idwt_module #(
  parameter int LENGTH = essentials::LENGTH
) (
  input  logic    clk,
  input  logic    reset,
  idwt_if.slave   bus
);
  import essentials::*;

  localparam int CNT_W = $clog2(LENGTH);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(LENGTH / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(LENGTH - 1);

  idwt_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       row_buf [LENGTH];
  logic [7:0]       lift_a;
  logic [7:0]       lift_b;
  logic [CNT_W-1:0] wr_even;
  logic [CNT_W-1:0] wr_odd;

  idwt_lift_unit u_lift (
    .s (bus.s),
    .d (bus.d),
    .a (lift_a),
    .b (lift_b)
  );

  assign wr_even = {cnt[CNT_W-2:0], 1'b0};
  assign wr_odd  = {cnt[CNT_W-2:0], 1'b1};

  // Row buffer is not reset; a discarded partial row is simply overwritten.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      row_buf[wr_even] <= lift_a;
      row_buf[wr_odd]  <= lift_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.rdy       <= 1'b1;
      bus.result    <= 1'b0;
      bus.out       <= 8'd0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.result <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            state   <= LOAD;
            cnt     <= '0;
            bus.rdy <= 1'b0;
          end
        end
        LOAD: begin
          if (cnt == LAST_PAIR) begin
            state      <= DONE;
            cnt        <= '0;
            bus.result <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Pixel 0 goes out together with the transition into EMIT.
          state         <= EMIT;
          bus.out       <= row_buf[0];
          bus.out_valid <= 1'b1;
          cnt           <= CNT_W'(1);
        end
        EMIT: begin
          // cnt returns to 0 after the last pixel; that marks the row end.
          if (cnt == '0) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.rdy       <= 1'b1;
          end else begin
            bus.out <= row_buf[cnt];
            cnt     <= (cnt == LAST_PIX) ? '0 : cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idwt_module.sv
module tb_idwt_module;
  localparam int L  = 8;
  localparam int NP = L / 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_q[$];
  int   last_exp = -1;
  int   row_s[NP];
  int   row_d[NP];

  idwt_if bus ();

  idwt_module #(.LENGTH(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference inverse lifting, integer arithmetic with floor shift.
  task automatic push_pair(input int sv, input int dv);
    int t, a, b;
    t = sv - (dv >>> 1);
    b = (t < 0) ? 0 : (t > 255) ? 255 : t;
    a = t + dv;
    a = (a < 0) ? 0 : (a > 255) ? 255 : a;
    exp_q.push_back(a);
    exp_q.push_back(b);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_pixel", 32'd1, 32'd0);
      end else begin
        last_exp = exp_q.pop_front();
        check("pixel", 32'(bus.out), 32'(last_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!bus.rdy && n < 100) begin
      step();
      n++;
    end
    if (!bus.rdy) check("rdy_timeout", 32'd0, 32'd1);
  endtask

  // Leaves the bench 1ns after the last LOAD edge (state DONE, result high).
  task automatic start_row(input bit keep_en, input bit glitch);
    wait_rdy();
    bus.en = 1'b1;
    step();
    bus.en = keep_en;
    for (int k = 0; k < NP; k++) begin
      bus.s = 8'(row_s[k]);
      bus.d = 8'(row_d[k]);
      push_pair(row_s[k], row_d[k]);
      if (glitch && k == 1) bus.en = 1'b1;
      else if (glitch) bus.en = keep_en;
      if (k == NP - 1) check("result_early", 32'(bus.result), 32'd0);
      step();
    end
    bus.en = keep_en;
    bus.s = 8'hxx;
    bus.d = 8'hxx;
    check("result", 32'(bus.result), 32'd1);
    check("rdy_busy", 32'(bus.rdy), 32'd0);
  endtask

  task automatic finish_row(input bit keep_en, input bit glitch);
    for (int i = 0; i < L; i++) begin
      if (glitch) bus.en = (i == 3) ? 1'b1 : keep_en;
      step();
    end
    check("rdy_early", 32'(bus.rdy), 32'd0);
    step();
    check("rdy_timing", 32'(bus.rdy), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("out_hold", 32'(bus.out), 32'(last_exp));
    check("valid_low", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    bus.en = 1'b1;
    bus.s  = 8'd0;
    bus.d  = 8'd0;
    // Test 1: reset held 3 cycles with en high
    repeat (3) step();
    check("rst_rdy", 32'(bus.rdy), 32'd1);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    bus.en = 1'b0;
    reset  = 1'b0;
    step();
    check("idle_rdy", 32'(bus.rdy), 32'd1);

    // Test 2: fixed pairs -> 105,95,50,50,50,0,240,255
    row_s = '{100, 50, 0, 250};
    row_d = '{10, 0, 100, -20};
    start_row(1'b0, 1'b0);
    finish_row(1'b0, 1'b0);
    step();

    // Test 3: same row, en pulses during LOAD and EMIT
    start_row(1'b0, 1'b1);
    finish_row(1'b0, 1'b1);
    step();
    check("no_restart", 32'(bus.rdy), 32'd1);

    // Test 4: reset on the 2nd EMIT cycle, then a row of 128s
    row_s = '{128, 200, 3, 77};
    row_d = '{-128, 127, -1, 1};
    start_row(1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    check("mid_rst_rdy", 32'(bus.rdy), 32'd1);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out", 32'(bus.out), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    step();
    for (int k = 0; k < NP; k++) begin
      row_s[k] = 128;
      row_d[k] = 0;
    end
    start_row(1'b0, 1'b0);
    finish_row(1'b0, 1'b0);
    check("last_128", 32'(last_exp), 32'd128);

    // Test 5: en held high, three back-to-back random rows
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NP; k++) begin
        row_s[k] = int'($urandom_range(0, 255));
        row_d[k] = int'($urandom_range(0, 255)) - 128;
      end
      start_row(r < 2, 1'b0);
      finish_row(r < 2, 1'b0);
    end
    bus.en = 1'b0;
    step();
    step();
    check("final_idle", 32'(bus.rdy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
